// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample averager: parameter defaults and FSM states.
package adc_pkg;

   localparam int ADC_BITS_DEFAULT = 14;
   localparam int AVG_LOG2_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ACCUM = 2'd2
   } avg_state_e;

endpackage

// File: rtl/adc_sample_averager_if.sv
// Result handshake bundle (data/valid/ready plus sticky overrun) for consumers of
// adc_sample_averager. The averager itself keeps flat ports for drop-in use.
interface adc_sample_averager_if #(
   parameter int ADCbits = 14
);

   logic [ADCbits-1:0] data;
   logic               valid;
   logic               ready;
   logic               overrun;

   modport master (output data, output valid, output overrun, input ready);
   modport slave  (input data, input valid, input overrun, output ready);

endinterface

// File: rtl/adc_clk_edge.sv
// Rising-edge strobe for the clk-derived ADC clock. adcClk is generated in the clk
// domain, so a single register suffices and no synchronizer is needed.
module adc_clk_edge (
   input  logic clk,
   input  logic rst,
   input  logic adcClk,
   output logic strobe
);

   logic adc_q;

   // Previous adcClk level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) adc_q <= 1'b0;
      else     adc_q <= adcClk;
   end

   assign strobe = adcClk & ~adc_q;

endmodule

// File: rtl/adc_sample_averager.sv
// Averages groups of 2^AvgLog2 ADC samples and presents each result through a
// valid/ready handshake with a sticky overrun flag for dropped results.
// Build option: define ADC_TWOS_COMP_EN to treat adcData as offset binary and
// produce two's-complement averages (signed accumulate, arithmetic shift).
module adc_sample_averager
   import adc_pkg::*;
#(
   parameter int ADCbits = ADC_BITS_DEFAULT,
   parameter int AvgLog2 = AVG_LOG2_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               adcClk,
   input  logic               adcReady,
   input  logic [ADCbits-1:0] adcData,
   output logic [ADCbits-1:0] outData,
   output logic               outValid,
   input  logic               outReady,
   output logic               overrun
);

   localparam int AW = ADCbits + AvgLog2;
   localparam int CW = (AvgLog2 > 0) ? AvgLog2 : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << AvgLog2) - 1);

   logic               strobe;
   logic               accept;
   logic               group_done;
   logic               xfer;
   avg_state_e         state_q, state_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [AW-1:0]      sample_ext;
   logic [AW-1:0]      sum;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [ADCbits-1:0] result;
   logic [ADCbits-1:0] data_q, data_d;
   logic               valid_q, valid_d;
   logic               ovr_q, ovr_d;

   adc_clk_edge u_edge (
      .clk    (clk),
      .rst    (rst),
      .adcClk (adcClk),
      .strobe (strobe)
   );

`ifdef ADC_TWOS_COMP_EN
   logic [ADCbits-1:0] conv;

   // Offset binary to two's complement: flip the MSB.
   always_comb begin
      conv              = adcData;
      conv[ADCbits-1]   = ~adcData[ADCbits-1];
   end

   assign sample_ext = AW'($signed(conv));
   assign result     = ADCbits'($signed(sum) >>> AvgLog2);
`else
   assign sample_ext = AW'(adcData);
   assign result     = ADCbits'(sum >> AvgLog2);
`endif

   assign sum        = acc_q + sample_ext;
   assign accept     = strobe & enable & adcReady;
   // With AvgLog2==0 CNT_LAST is 0 and the count never leaves 0, so every sample completes.
   assign group_done = accept & (cnt_q == CNT_LAST);
   assign xfer       = valid_q & outReady;

   // Capture state tracking: idle until enabled, wait for the receiver pipeline.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = WAIT;
            WAIT:    if (adcReady) state_d = ACCUM;
            ACCUM:   state_d = ACCUM;
            default: state_d = IDLE;
         endcase
      end
   end

   // Accumulator and sample count; disabling discards any partial group.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (!enable || group_done) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         acc_d = sum;
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Result register: load when empty or being drained this edge, otherwise drop and flag.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (xfer) valid_d = 1'b0;
      if (group_done) begin
         if (!valid_q || xfer) begin
            data_d  = result;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign outData  = data_q;
   assign outValid = valid_q;
   assign overrun  = ovr_q;

endmodule
